// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared types and constants for the single-port register-file writeback
// arbiter and its multi-cycle result queue.
//   arb_state_e : arbiter priority state (ALU_PRI after reset, MC_PRI for one
//                 cycle after the queue head has been starved)
//   gnt_sel_e   : which source owns the writeback port this cycle
//   wb_entry_t  : one queued multi-cycle result (destination + data)
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic {
        ALU_PRI = 1'b0,
        MC_PRI  = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MC   = 2'd2
    } gnt_sel_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_port_arbiter_mc.sv
// -----------------------------------------------------------------------------
// wb_mc_fifo
// In-order queue for multi-cycle (load/mul/div) results awaiting the shared
// writeback port. The head is presented combinationally so the arbiter can
// write it back in the same cycle it is popped; a pushed entry only becomes
// visible at the head on the following cycle (no bypass).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push, push_data       write an entry (ignored when full)
//   pop                   remove the head entry (ignored when empty)
//   head_data             current head entry
//   full, empty, count    occupancy status (count is 0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module wb_mc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the ALU (execute stage)
// and a queue of multi-cycle unit results. The ALU normally wins; if a queued
// result loses STARVE_LIMIT consecutive times the arbiter spends one cycle in
// MC_PRI, stalls the ALU and writes the queue head.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data        ALU result in; alu_ready = accepted
//   mc_valid/mc_rd/mc_data           multi-cycle result in; mc_ready = queued
//   wb_we/wb_rd/wb_data              registered register-file write port
//   mc_pending                       queue non-empty (hazard hold)
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MC_DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mc_valid,
    input  logic [REG_IDX_W-1:0] mc_rd,
    input  logic [DATA_W-1:0]    mc_data,
    output logic                 mc_ready,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 mc_pending
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W    = $clog2(MC_DEPTH) + 1;

    arb_state_e           state_q, state_d;
    logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic                 wb_we_q, wb_we_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;

    gnt_sel_e             gnt;
    wb_entry_t            mc_entry;
    wb_entry_t            fifo_head;
    logic [WB_ENTRY_W-1:0] fifo_head_bits;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [DATA_W-1:0]    sel_data;

    assign mc_entry  = '{rd: mc_rd, data: mc_data};
    assign fifo_head = wb_entry_t'(fifo_head_bits);

    wb_mc_fifo #(
        .DEPTH (MC_DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_mc_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (mc_valid && mc_ready),
        .push_data (mc_entry),
        .pop       (gnt == GNT_MC),
        .head_data (fifo_head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mc_ready   = !fifo_full;
    assign mc_pending = (fifo_count != '0);
    assign alu_ready  = (state_q == ALU_PRI);

    // Arbitration and starvation tracking.
    always_comb begin
        gnt          = GNT_NONE;
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ALU_PRI: begin
                if (alu_valid) begin
                    gnt = GNT_ALU;
                end else if (!fifo_empty) begin
                    gnt = GNT_MC;
                end
                // Count only losses suffered by a waiting queue head.
                if (fifo_empty || (gnt == GNT_MC)) begin
                    starve_cnt_d = '0;
                end else if ((gnt == GNT_ALU) &&
                             (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
                    starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                end
                if (starve_cnt_d == STARVE_W'(STARVE_LIMIT)) begin
                    state_d = MC_PRI;
                end
            end
            MC_PRI: begin
                // Entry here implies a non-empty queue; the check only guards
                // against popping nothing.
                if (!fifo_empty) begin
                    gnt = GNT_MC;
                end
                starve_cnt_d = '0;
                state_d      = ALU_PRI;
            end
            default: begin
                state_d      = ALU_PRI;
                starve_cnt_d = '0;
            end
        endcase
    end

    // Writeback port: rd == 0 completes the handshake but writes nothing, and
    // address/data hold their last written values otherwise.
    always_comb begin
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (gnt == GNT_MC) begin
            sel_rd   = fifo_head.rd;
            sel_data = fifo_head.data;
        end
        if ((gnt != GNT_NONE) && (sel_rd != '0)) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ALU_PRI;
            starve_cnt_q <= '0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed bench for wb_port_arbiter (STARVE_LIMIT=4, MC_DEPTH=2). Inputs are
// driven 2 time units after each rising edge; outputs are sampled 1 unit later,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_pending;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(
        .STARVE_LIMIT (4),
        .MC_DEPTH     (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mc_valid   (mc_valid),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mc_pending (mc_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
        chk({tag, ".we"},   {31'd0, wb_we}, {31'd0, we});
        chk({tag, ".rd"},   {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, ".data"}, wb_data, data);
        $display("[%0t] %s wb_we=%0b wb_rd=%0d wb_data=%h", $time, tag, wb_we, wb_rd, wb_data);
    endtask

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mc_valid  = 1'b0;
        mc_rd     = '0;
        mc_data   = '0;

        // ---- reset values ----
        tick();
        tick();
        chk_wb("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.mc_pending", {31'd0, mc_pending}, 32'd0);
        chk("rst.mc_ready",   {31'd0, mc_ready},   32'd1);
        chk("rst.alu_ready",  {31'd0, alu_ready},  32'd1);

        // ---- single MC result, rd=3 data=0xAA ----
        reset_n  = 1'b1;
        mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'hAA;
        tick();                                   // pushed on that edge
        mc_valid = 1'b0;
        #1 chk("mc1.pending", {31'd0, mc_pending}, 32'd1);
        chk_wb("mc1.pre", 1'b0, 5'd0, 32'h0);
        tick();                                   // granted on that edge
        #1 chk_wb("mc1.wr", 1'b1, 5'd3, 32'hAA);
        chk("mc1.pending_clr", {31'd0, mc_pending}, 32'd0);

        // ---- ALU write to rd=0 is swallowed ----
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1 chk("rd0.alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        #1 chk_wb("rd0.wr", 1'b0, 5'd3, 32'hAA);

        // ---- starvation: ALU held, one MC queued ----
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h100;
        mc_valid  = 1'b1; mc_rd  = 5'd7; mc_data  = 32'h77;
        tick();
        mc_valid = 1'b0; alu_data = 32'h101;
        #1 chk_wb("stv.c1", 1'b1, 5'd5, 32'h100);
        chk("stv.c1.pending", {31'd0, mc_pending}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1 chk_wb("stv.alu", 1'b1, 5'd5, 32'h100 + 32'(i));
            chk("stv.alu_ready", {31'd0, alu_ready}, 32'd1);
            alu_data = 32'h101 + 32'(i);
        end
        tick();
        #1 chk_wb("stv.c5", 1'b1, 5'd5, 32'h104);
        chk("stv.c5.alu_ready", {31'd0, alu_ready}, 32'd0);
        alu_data = 32'h105;
        tick();
        #1 chk_wb("stv.mcwr", 1'b1, 5'd7, 32'h77);
        chk("stv.c6.alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        #1 chk_wb("stv.resume", 1'b1, 5'd5, 32'h105);
        tick();
        #1 chk_wb("stv.idle", 1'b0, 5'd5, 32'h105);
        chk("stv.pending", {31'd0, mc_pending}, 32'd0);

        // ---- three back-to-back MC results with ALU saturating ----
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h200;
        mc_valid  = 1'b1; mc_rd  = 5'd10; mc_data = 32'hA1;
        #1 chk("q3.d0.mc_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_rd = 5'd11; mc_data = 32'hA2; alu_data = 32'h201;
        #1 chk("q3.d1.mc_ready", {31'd0, mc_ready}, 32'd1);
        chk_wb("q3.d1", 1'b1, 5'd9, 32'h200);
        tick();
        mc_rd = 5'd12; mc_data = 32'hA3; alu_data = 32'h202;
        #1 chk("q3.d2.mc_ready", {31'd0, mc_ready}, 32'd0);
        chk_wb("q3.d2", 1'b1, 5'd9, 32'h201);
        tick();
        alu_data = 32'h203;
        #1 chk("q3.d3.mc_ready", {31'd0, mc_ready}, 32'd0);
        tick();
        alu_data = 32'h204;
        #1 chk_wb("q3.d4", 1'b1, 5'd9, 32'h203);
        tick();
        alu_data = 32'h205;
        #1 chk("q3.d5.alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("q3.d5.mc_ready",  {31'd0, mc_ready},  32'd0);
        tick();
        #1 chk_wb("q3.d6", 1'b1, 5'd10, 32'hA1);
        chk("q3.d6.mc_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        alu_valid = 1'b0; mc_valid = 1'b0;
        #1 chk_wb("q3.d7", 1'b1, 5'd9, 32'h205);
        tick();
        #1 chk_wb("q3.d8", 1'b1, 5'd11, 32'hA2);
        tick();
        #1 chk_wb("q3.d9", 1'b1, 5'd12, 32'hA3);
        tick();
        #1 chk_wb("q3.d10", 1'b0, 5'd12, 32'hA3);
        chk("q3.d10.pending", {31'd0, mc_pending}, 32'd0);

        // ---- simultaneous push and pop at count=1 ----
        mc_valid = 1'b1; mc_rd = 5'd13; mc_data = 32'hB1;
        tick();
        mc_rd = 5'd14; mc_data = 32'hB2;
        #1 chk("pp.e1.mc_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;
        #1 chk_wb("pp.e2", 1'b1, 5'd13, 32'hB1);
        chk("pp.e2.pending",  {31'd0, mc_pending}, 32'd1);
        chk("pp.e2.mc_ready", {31'd0, mc_ready},   32'd1);
        tick();
        #1 chk_wb("pp.e3", 1'b1, 5'd14, 32'hB2);
        chk("pp.e3.pending", {31'd0, mc_pending}, 32'd0);

        // ---- async reset while in MC_PRI with two queued entries ----
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h300;
        mc_valid  = 1'b1; mc_rd  = 5'd15; mc_data = 32'hC1;
        tick();
        mc_rd = 5'd16; mc_data = 32'hC2;
        tick();
        mc_valid = 1'b0;
        tick();
        tick();
        tick();
        #1 chk("ar.alu_ready", {31'd0, alu_ready}, 32'd0);
        chk_wb("ar.pre", 1'b1, 5'd9, 32'h300);
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        #1 chk_wb("ar.rst", 1'b0, 5'd0, 32'h0);
        chk("ar.rst.pending",   {31'd0, mc_pending}, 32'd0);
        chk("ar.rst.mc_ready",  {31'd0, mc_ready},   32'd1);
        chk("ar.rst.alu_ready", {31'd0, alu_ready},  32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        #1 chk_wb("ar.post1", 1'b0, 5'd0, 32'h0);
        tick();
        #1 chk_wb("ar.post2", 1'b0, 5'd0, 32'h0);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h400;
        tick();
        alu_valid = 1'b0;
        #1 chk_wb("ar.first", 1'b1, 5'd4, 32'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
